param_alu_seq: RTL and testbench

//   Parametrised sequential two-operand ALU for the TinyTapeout user area; next generation of the 4-bit load-A/load-B adder.

---
 rtl/param_alu_seq.sv | 105 ++++++++++
 tb/tb_param_alu_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_alu_seq.sv
// Sequential WIDTH-bit add/sub ALU with serial operand loading, signed overflow,
// optional unsigned saturation and chained accumulation while a result is held.
module param_alu_seq #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_a,
  input  logic             load_b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             ready,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    LOADED_A = 2'b01,
    RES      = 2'b10,
    BAD      = 2'b11
  } state_t;

  state_t           st;
  logic [WIDTH-1:0] reg_a;
  logic             done_q;

  logic [WIDTH-1:0] x;
  logic [WIDTH:0]   full;
  logic [WIDTH-1:0] res_n;
  logic             c_n;
  logic             v_n;

  // In RESULT the stored (possibly clamped) result is the left operand, enabling chaining.
  assign x = (st == RES) ? result : reg_a;

  always_comb begin
    full  = op[0] ? ({1'b0, x} - {1'b0, data_in}) : ({1'b0, x} + {1'b0, data_in});
    c_n   = full[WIDTH];
    v_n   = op[0] ? ((x[WIDTH-1] != data_in[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]))
                  : ((x[WIDTH-1] == data_in[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]));
    res_n = full[WIDTH-1:0];
    if (SATURATE && c_n) res_n = op[0] ? '0 : '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      reg_a    <= '0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      done_q   <= 1'b0;
    end else if (!ena) begin
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (st)
        IDLE: begin
          if (load_a) begin
            reg_a <= data_in;
            st    <= LOADED_A;
          end
        end
        LOADED_A: begin
          if (load_b) begin
            result   <= res_n;
            carry    <= c_n;
            overflow <= v_n;
            done_q   <= 1'b1;
            st       <= RES;
          end else if (load_a) begin
            reg_a <= data_in;
          end
        end
        RES: begin
          if (load_a) begin
            reg_a <= data_in;
            st    <= LOADED_A;
          end else if (load_b) begin
            if (op[1]) begin
              result   <= res_n;
              carry    <= c_n;
              overflow <= v_n;
              done_q   <= 1'b1;
            end
          end else begin
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign ready = (st == RES);
  assign done  = done_q & ena;
  assign state = st;

endmodule

// File: tb/tb_param_alu_seq.sv
// Scoreboard bench: a 4-bit wrapping ALU and an 8-bit saturating ALU; expected
// results are queued when load_b is driven and checked when done pulses.
module tb_param_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [3:0] data4 = '0;
  logic [7:0] data8 = '0;
  logic       la4 = 1'b0, lb4 = 1'b0, la8 = 1'b0, lb8 = 1'b0;
  logic [1:0] op4 = '0, op8 = '0;

  logic [3:0] result4;
  logic       carry4, ovf4, ready4, done4;
  logic [1:0] state4;
  logic [7:0] result8;
  logic       carry8, ovf8, ready8, done8;
  logic [1:0] state8;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       v;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  logic [7:0] cur4 = '0;
  logic [7:0] cur8 = '0;

  param_alu_seq #(.WIDTH(4), .SATURATE(1'b0)) u4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data4), .load_a(la4), .load_b(lb4),
    .op(op4), .result(result4), .carry(carry4), .overflow(ovf4), .ready(ready4),
    .done(done4), .state(state4)
  );

  param_alu_seq #(.WIDTH(8), .SATURATE(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data8), .load_a(la8), .load_b(lb8),
    .op(op8), .result(result8), .carry(carry8), .overflow(ovf8), .ready(ready8),
    .done(done8), .state(state8)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(int w, bit sat, int x, int y, bit sub);
    exp_t e;
    int mask, full, msb, rm;
    mask = (1 << w) - 1;
    msb  = w - 1;
    full = sub ? (x - y) : (x + y);
    rm   = full & mask;
    e.c  = sub ? (x < y) : (full > mask);
    e.r  = 8'(rm);
    if (sub) e.v = (((x >> msb) & 1) != ((y >> msb) & 1)) && (((rm >> msb) & 1) != ((x >> msb) & 1));
    else     e.v = (((x >> msb) & 1) == ((y >> msb) & 1)) && (((rm >> msb) & 1) != ((x >> msb) & 1));
    if (sat && e.c) e.r = sub ? 8'd0 : 8'(mask);
    return e;
  endfunction

  // Output monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done4 === 1'b1) begin
      total++;
      if (q4.size() == 0) begin
        bad++;
        $display("FAIL done4_unexpected: got done=1 with result=%h, need no pulse", result4);
      end else begin
        e = q4.pop_front();
        if ({result4, carry4, ovf4} !== {e.r[3:0], e.c, e.v}) begin
          bad++;
          $display("FAIL result4: got r=%h c=%b v=%b, need r=%h c=%b v=%b",
                   result4, carry4, ovf4, e.r[3:0], e.c, e.v);
        end
      end
    end
    if (rst_n && done8 === 1'b1) begin
      total++;
      if (q8.size() == 0) begin
        bad++;
        $display("FAIL done8_unexpected: got done=1 with result=%h, need no pulse", result8);
      end else begin
        e = q8.pop_front();
        if ({result8, carry8, ovf8} !== {e.r, e.c, e.v}) begin
          bad++;
          $display("FAIL result8: got r=%h c=%b v=%b, need r=%h c=%b v=%b",
                   result8, carry8, ovf8, e.r, e.c, e.v);
        end
      end
    end
  end

  task automatic cyc4(input bit la, input bit lb, input logic [3:0] d, input logic [1:0] o);
    la4 = la; lb4 = lb; data4 = d; op4 = o;
    @(posedge clk); #1;
    la4 = 1'b0; lb4 = 1'b0;
  endtask

  task automatic cyc8(input bit la, input bit lb, input logic [7:0] d, input logic [1:0] o);
    la8 = la; lb8 = lb; data8 = d; op8 = o;
    @(posedge clk); #1;
    la8 = 1'b0; lb8 = 1'b0;
  endtask

  // Lets the monitor drain, then any expectation left over means a missing done.
  task automatic drain(input string name);
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (q4.size() != 0 || q8.size() != 0) begin
      bad++;
      $display("FAIL %s_pending: got %0d/%0d results outstanding, need 0/0", name, q4.size(), q8.size());
      q4.delete(); q8.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({state4, result4, carry4, ovf4, ready4, done4} !== 10'b0) begin
      bad++;
      $display("FAIL reset4: got st=%b r=%h c=%b v=%b rdy=%b d=%b, need all 0",
               state4, result4, carry4, ovf4, ready4, done4);
    end
    total++;
    if ({state8, result8, carry8, ovf8, ready8, done8} !== 14'b0) begin
      bad++;
      $display("FAIL reset8: got st=%b r=%h, need all 0", state8, result8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    exp_t e;
    cyc4(1, 0, 4'd9, 2'b00);
    e = model(4, 0, 9, 8, 0); q4.push_back(e); cur4 = e.r;
    cyc4(0, 1, 4'd8, 2'b00);
    total++;
    if ({state4, ready4, done4} !== {2'b10, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL add_ctrl: got st=%b rdy=%b done=%b, need 10 1 1", state4, ready4, done4);
    end
    drain("add");
  endtask

  task automatic test_sub();
    exp_t e;
    cyc4(1, 0, 4'd3, 2'b00);
    e = model(4, 0, 3, 5, 1); q4.push_back(e); cur4 = e.r;
    cyc4(0, 1, 4'd5, 2'b01);
    drain("sub");
  endtask

  task automatic test_chain();
    exp_t e;
    cyc4(1, 0, 4'd5, 2'b00);
    e = model(4, 0, 5, 6, 0); q4.push_back(e); cur4 = e.r;
    cyc4(0, 1, 4'd6, 2'b10);
    e = model(4, 0, int'(cur4), 3, 0); q4.push_back(e); cur4 = e.r;
    cyc4(0, 1, 4'd3, 2'b10);
    total++;
    if (state4 !== 2'b10) begin
      bad++;
      $display("FAIL chain_state: got %b, need 10", state4);
    end
    drain("chain");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [3:0] a, d;
    logic [1:0] o;
    a = 4'($urandom_range(0, 15));
    cyc4(1, 0, a, 2'b00);
    d = 4'($urandom_range(0, 15));
    e = model(4, 0, int'(a), int'(d), 0); q4.push_back(e); cur4 = e.r;
    cyc4(0, 1, d, 2'b00);
    for (int i = 0; i < 6; i++) begin
      d = 4'($urandom_range(0, 15));
      o = {1'b1, 1'($urandom_range(0, 1))};
      e = model(4, 0, int'(cur4), int'(d), o[0]); q4.push_back(e); cur4 = e.r;
      cyc4(0, 1, d, o);
    end
    // load_b without the chain bit must leave result alone and stay in RESULT
    cyc4(0, 1, 4'd7, 2'b01);
    total++;
    if ({state4, result4} !== {2'b10, cur4[3:0]}) begin
      bad++;
      $display("FAIL nochain_hold: got st=%b r=%h, need 10 %h", state4, result4, cur4[3:0]);
    end
    drain("b2b");
    total++;
    if ({state4, result4} !== {2'b00, cur4[3:0]}) begin
      bad++;
      $display("FAIL idle_keep: got st=%b r=%h, need 00 %h", state4, result4, cur4[3:0]);
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    cyc8(1, 0, 8'd200, 2'b00);
    e = model(8, 1, 200, 100, 0); q8.push_back(e); cur8 = e.r;
    cyc8(0, 1, 8'd100, 2'b00);
    e = model(8, 1, int'(cur8), 1, 0); q8.push_back(e); cur8 = e.r;
    cyc8(0, 1, 8'd1, 2'b10);
    drain("sat_add");
    cyc8(1, 0, 8'd10, 2'b00);
    e = model(8, 1, 10, 20, 1); q8.push_back(e); cur8 = e.r;
    cyc8(0, 1, 8'd20, 2'b01);
    drain("sat_sub");
  endtask

  task automatic test_control();
    exp_t e;
    ena = 1'b0;
    cyc4(1, 0, 4'd7, 2'b00);
    total++;
    if ({state4, result4} !== {2'b00, cur4[3:0]}) begin
      bad++;
      $display("FAIL ena_hold: got st=%b r=%h, need 00 %h", state4, result4, cur4[3:0]);
    end
    ena = 1'b1;
    cyc4(1, 0, 4'd2, 2'b00);
    e = model(4, 0, 2, 3, 0); q4.push_back(e); cur4 = e.r;
    cyc4(0, 1, 4'd3, 2'b00);
    cyc4(1, 1, 4'd4, 2'b10);
    total++;
    if ({state4, ready4} !== {2'b01, 1'b0}) begin
      bad++;
      $display("FAIL both_strobes: got st=%b rdy=%b, need 01 0", state4, ready4);
    end
    e = model(4, 0, 4, 1, 0); q4.push_back(e); cur4 = e.r;
    cyc4(0, 1, 4'd1, 2'b00);
    drain("control");
    total++;
    if ({state4, result4} !== {2'b00, cur4[3:0]}) begin
      bad++;
      $display("FAIL drop_idle: got st=%b r=%h, need 00 %h", state4, result4, cur4[3:0]);
    end
  endtask

  task automatic test_reset_mid();
    cyc4(1, 0, 4'd6, 2'b00);
    total++;
    if (state4 !== 2'b01) begin
      bad++;
      $display("FAIL pre_reset_state: got %b, need 01", state4);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({state4, result4, carry4, ovf4, ready4, done4} !== 10'b0) begin
      bad++;
      $display("FAIL reset_mid: got st=%b r=%h c=%b v=%b rdy=%b d=%b, need all 0",
               state4, result4, carry4, ovf4, ready4, done4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cur4 = '0;
    cyc4(0, 1, 4'd5, 2'b00);
    total++;
    if ({state4, result4, ready4} !== {2'b00, 4'h0, 1'b0}) begin
      bad++;
      $display("FAIL lone_load_b: got st=%b r=%h rdy=%b, need 00 0 0", state4, result4, ready4);
    end
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_chain();
    test_back_to_back();
    test_saturate();
    test_control();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
